seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 87 ++++++++
 tb/tb_seg_scan_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: double-buffered display value, one digit slot per
// TICKS cycles, dead cycle at slot start, and live leading-zero suppression.
module seg_scan_ctrl #(
   parameter int NDIGITS = 8,
   parameter int TICKS   = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] in_data,
   input  logic [NDIGITS-1:0]   in_blank,
   input  logic                 lz_en,
   output logic [3:0]           nibble,
   output logic                 blank,
   output logic [NDIGITS-1:0]   dig_sel,
   output logic                 frame_done
);

   localparam int TW = $clog2(TICKS);
   localparam int IW = $clog2(NDIGITS);
   localparam int DW = 4 * NDIGITS;
   localparam logic [TW-1:0]      TICK_LAST = TW'(TICKS - 1);
   localparam logic [IW-1:0]      IDX_LAST  = IW'(NDIGITS - 1);
   localparam logic [NDIGITS-1:0] SEL_ONE   = NDIGITS'(1);

   logic [TW-1:0]      r_tick;
   logic [IW-1:0]      r_idx;
   logic [DW-1:0]      r_disp_data;
   logic [NDIGITS-1:0] r_disp_blank;
   logic [DW-1:0]      r_pend_data;
   logic [NDIGITS-1:0] r_pend_blank;
   logic               r_pend_full;

   logic               w_tick_last;
   logic               w_fe;
   logic               w_accept;
   logic               w_dead;
   logic               w_lz;
   logic [IW+1:0]      w_bit_ofs;

   assign w_tick_last = (r_tick == TICK_LAST);
   assign w_fe        = w_tick_last && (r_idx == IDX_LAST);
   assign in_ready    = rst_n && !r_pend_full;
   assign w_accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tick       <= '0;
         r_idx        <= '0;
         r_disp_data  <= '0;
         r_disp_blank <= '1;
         r_pend_data  <= '0;
         r_pend_blank <= '1;
         r_pend_full  <= 1'b0;
      end else begin
         if (w_tick_last) begin
            r_tick <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end else begin
            r_tick <= r_tick + TW'(1);
         end

         // Commit needs pend_full, which forces in_ready low, so it never meets an accept.
         if (w_fe && r_pend_full) begin
            r_disp_data  <= r_pend_data;
            r_disp_blank <= r_pend_blank;
            r_pend_full  <= 1'b0;
         end else if (w_accept) begin
            r_pend_data  <= in_data;
            r_pend_blank <= in_blank;
            r_pend_full  <= 1'b1;
         end
      end
   end

   assign w_bit_ofs = {r_idx, 2'b00};
   assign w_dead    = (r_tick == '0);
   // Suppress when this digit and every more significant one are zero; digit 0 always shows.
   assign w_lz      = lz_en && (r_idx != '0) && ((r_disp_data >> w_bit_ofs) == '0);

   assign nibble     = r_disp_data[w_bit_ofs +: 4];
   assign dig_sel    = w_dead ? '1 : ~(SEL_ONE << r_idx);
   assign blank      = r_disp_blank[r_idx] | w_lz | w_dead;
   assign frame_done = w_fe;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIGITS=4, TICKS=4: every cycle's outputs are
// checked against a hand-maintained expected display state, plus fixed spot values.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_blank;
   logic        lz_en;
   logic [3:0]  nibble;
   logic        blank;
   logic [3:0]  dig_sel;
   logic        frame_done;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;

   logic [15:0] exp_disp;
   logic [3:0]  exp_bmask;
   logic        exp_ready;

   seg_scan_ctrl #(.NDIGITS(4), .TICKS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_blank   (in_blank),
      .lz_en      (lz_en),
      .nibble     (nibble),
      .blank      (blank),
      .dig_sel    (dig_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, want);
      end
   endtask

   // Expected outputs for the current cycle, derived from cycle number and exp_* state.
   task automatic check_cycle();
      int         m_tick;
      int         m_idx;
      logic [3:0] e_dsel;
      logic       e_lz;
      m_tick = cyc % 4;
      m_idx  = (cyc / 4) % 4;
      e_dsel = (m_tick == 0) ? 4'hF : ~(4'b0001 << m_idx);
      e_lz   = lz_en && (m_idx != 0) && ((exp_disp >> (4 * m_idx)) == 16'h0);
      chk("dig_sel",    dig_sel,    e_dsel);
      chk("nibble",     nibble,     exp_disp[4*m_idx +: 4]);
      chk("blank",      blank,      exp_bmask[m_idx] | e_lz | (m_tick == 0));
      chk("frame_done", frame_done, (m_tick == 3) && (m_idx == 3));
      chk("in_ready",   in_ready,   exp_ready);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0;
      in_blank = 4'h0;
      lz_en    = 1'b0;
      step();
      step();

      chk("rst_in_ready",   in_ready,   1'b0);
      chk("rst_dig_sel",    dig_sel,    4'hF);
      chk("rst_blank",      blank,      1'b1);
      chk("rst_nibble",     nibble,     4'h0);
      chk("rst_frame_done", frame_done, 1'b0);

      rst_n     = 1'b1;
      exp_disp  = 16'h0;
      exp_bmask = 4'hF;
      exp_ready = 1'b1;

      for (int c = 0; c <= 106; c++) begin
         cyc = c;
         case (c)
            3:   begin in_valid = 1'b1; in_data = 16'h12A4; in_blank = 4'h0; end
            4:   begin in_valid = 1'b0; exp_ready = 1'b0; end
            16:  begin exp_disp = 16'h12A4; exp_bmask = 4'h0; exp_ready = 1'b1; end
            20:  begin in_valid = 1'b1; in_data = 16'h1111; end
            21:  begin in_data = 16'h2222; exp_ready = 1'b0; end
            32:  begin exp_disp = 16'h1111; exp_ready = 1'b1; end
            33:  begin in_valid = 1'b0; exp_ready = 1'b0; end
            48:  begin exp_disp = 16'h2222; exp_ready = 1'b1; end
            63:  begin in_valid = 1'b1; in_data = 16'h0050; end
            64:  begin in_valid = 1'b0; exp_ready = 1'b0; end
            80:  begin exp_disp = 16'h0050; exp_ready = 1'b1; lz_en = 1'b1; end
            82:  begin in_valid = 1'b1; in_data = 16'h0000; end
            83:  begin in_valid = 1'b0; exp_ready = 1'b0; end
            96:  begin exp_disp = 16'h0000; exp_ready = 1'b1; end
            102: lz_en = 1'b0;
            104: begin in_valid = 1'b1; in_data = 16'h7777; end
            105: begin in_valid = 1'b0; exp_ready = 1'b0; end
            106: rst_n = 1'b0;
            default: ;
         endcase
         #1;
         check_cycle();
         case (c)
            1:   chk("hand_dsel_c1",   dig_sel,    4'hE);
            5:   chk("hand_dsel_c5",   dig_sel,    4'hD);
            15:  chk("hand_fe_c15",    frame_done, 1'b1);
            17:  chk("hand_nib_d0",    nibble,     4'h4);
            21:  chk("hand_nib_d1",    nibble,     4'hA);
            25:  chk("hand_nib_d2",    nibble,     4'h2);
            29:  chk("hand_nib_d3",    nibble,     4'h1);
            33:  chk("hand_nib_1111",  nibble,     4'h1);
            49:  chk("hand_nib_2222",  nibble,     4'h2);
            65:  chk("hand_fe_accept", nibble,     4'h2);
            81:  chk("hand_lz_d0",     blank,      1'b0);
            85:  chk("hand_lz_d1_nib", nibble,     4'h5);
            89:  chk("hand_lz_d2",     blank,      1'b1);
            93:  chk("hand_lz_d3",     blank,      1'b1);
            97:  chk("hand_zero_d0",   blank,      1'b0);
            101: chk("hand_zero_d1",   blank,      1'b1);
            102: chk("hand_lz_off",    blank,      1'b0);
            106: chk("hand_rst_ready", in_ready,   1'b0);
            default: ;
         endcase
         step();
      end

      cyc = 107;
      chk("midrst_in_ready",   in_ready,   1'b0);
      chk("midrst_dig_sel",    dig_sel,    4'hF);
      chk("midrst_blank",      blank,      1'b1);
      chk("midrst_nibble",     nibble,     4'h0);
      chk("midrst_frame_done", frame_done, 1'b0);

      // After release the discarded 0x7777 must never show; display stays dark for two frames.
      rst_n     = 1'b1;
      exp_disp  = 16'h0;
      exp_bmask = 4'hF;
      exp_ready = 1'b1;
      for (int c = 0; c < 32; c++) begin
         cyc = c;
         #1;
         check_cycle();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
